// File: rtl/speaker_scheduler_pkg.sv
// Shared types and helpers for the speaker scheduler: FSM state encoding,
// default field widths and the fixed-priority request selector.
package speaker_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int HP_W_DEF  = 18;
    localparam int DUR_W_DEF = 12;
    localparam int REQ_MAX   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Isolates the lowest set bit, so index 0 always wins.
    function automatic logic [REQ_MAX-1:0] pri_onehot(input logic [REQ_MAX-1:0] r);
        return r & (~r + REQ_MAX'(1));
    endfunction

endpackage

// File: rtl/speaker_scheduler_if.sv
// Requester-side bus of the speaker scheduler: packed requests, handshake
// pulses and the speaker drive.
interface speaker_scheduler_if
    import speaker_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int HP_W  = HP_W_DEF,
    parameter int DUR_W = DUR_W_DEF
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*HP_W-1:0]  req_hp;
    logic [N_REQ*DUR_W-1:0] req_dur;
    logic                   abort;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   done;
    logic                   speaker;

    modport master (
        output req, req_hp, req_dur, abort,
        input  grant, busy, done, speaker
    );

    modport slave (
        input  req, req_hp, req_dur, abort,
        output grant, busy, done, speaker
    );
endinterface

// File: rtl/speaker_scheduler_tone_divider.sv
// Square-wave generator: toggles out every half_period cycles while en is high,
// returns to a cleared, silent state whenever en drops. half_period==0 is a rest.
module tone_divider #(
    parameter int HP_W = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            out
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en || half_period == '0) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (cnt == half_period - HP_W'(1)) begin
            cnt <= '0;
            out <= ~out;
        end else begin
            cnt <= cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/speaker_scheduler.sv
// Shares one speaker between prioritised requesters: grants one note, plays it
// for a number of ms ticks, then holds a silent gap before the next grant.
//
//   state | meaning
//   IDLE  | waiting for any request; lowest index wins
//   PLAY  | tone running, duration ticks counting down
//   GAP   | speaker silent, gap ticks counting down
module speaker_scheduler
    import speaker_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int HP_W        = HP_W_DEF,
    parameter int DUR_W       = DUR_W_DEF,
    parameter int TICK_CYCLES = 100000,
    parameter int GAP_TICKS   = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    speaker_scheduler_if.slave  bus
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_CYCLES - 1);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q;
    logic [DUR_W-1:0]   rem_q;
    logic [GAP_W-1:0]   gap_q;
    logic [HP_W-1:0]    hp_q;
    logic [N_REQ-1:0]   grant_q;
    logic               done_q;

    logic [REQ_MAX-1:0] sel_full;
    logic [N_REQ-1:0]   sel;
    logic               req_any;
    logic [HP_W-1:0]    hp_sel;
    logic [DUR_W-1:0]   dur_sel;
    logic               start, to_gap;
    logic               tick_tc, play_end, gap_end;
    logic               tone_out;

    assign sel_full = pri_onehot(REQ_MAX'(bus.req));
    assign sel      = sel_full[N_REQ-1:0];
    assign req_any  = |sel_full;

    always_comb begin
        hp_sel  = '0;
        dur_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel[i]) begin
                hp_sel  = bus.req_hp[i*HP_W +: HP_W];
                dur_sel = bus.req_dur[i*DUR_W +: DUR_W];
            end
        end
    end

    // A zero count means the phase is already on its last cycle.
    assign tick_tc  = (tick_q == '0);
    assign play_end = (rem_q == '0) || (rem_q == DUR_W'(1) && tick_tc);
    assign gap_end  = (gap_q == '0) || (gap_q == GAP_W'(1) && tick_tc);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        to_gap  = 1'b0;
        case (state_q)
            IDLE: if (req_any) begin
                state_d = PLAY;
                start   = 1'b1;
            end
            PLAY: if (bus.abort || play_end) begin
                state_d = GAP;
                to_gap  = 1'b1;
            end
            GAP:  if (gap_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            hp_q    <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= start ? sel : '0;
            done_q  <= to_gap;

            if (start || to_gap || (state_q != IDLE && tick_tc))
                tick_q <= TICK_RELOAD;
            else if (state_q != IDLE)
                tick_q <= tick_q - TICK_W'(1);

            if (start) begin
                rem_q <= dur_sel;
                hp_q  <= hp_sel;
            end else if (state_q == PLAY && tick_tc && rem_q != '0) begin
                rem_q <= rem_q - DUR_W'(1);
            end

            if (to_gap)
                gap_q <= GAP_W'(GAP_TICKS);
            else if (state_q == GAP && tick_tc && gap_q != '0)
                gap_q <= gap_q - GAP_W'(1);
        end
    end

    tone_divider #(.HP_W(HP_W)) u_tone (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (state_q == PLAY),
        .half_period (hp_q),
        .out         (tone_out)
    );

    // Gate with state so the first GAP cycle is silent before the divider clears.
    assign bus.speaker = tone_out & (state_q == PLAY);
    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_speaker_scheduler.sv
// Directed bench for speaker_scheduler with TICK_CYCLES=4, GAP_TICKS=2.
module tb_speaker_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    speaker_scheduler_if #(.N_REQ(4), .HP_W(18), .DUR_W(12)) bus ();

    speaker_scheduler #(
        .N_REQ(4), .HP_W(18), .DUR_W(12), .TICK_CYCLES(4), .GAP_TICKS(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic load(input int i, input int hp, input int dur);
        bus.req_hp[i*18 +: 18]  = 18'(hp);
        bus.req_dur[i*12 +: 12] = 12'(dur);
    endtask

    // Negedges until busy drops; -1 if it never does.
    task automatic wait_busy_low(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '0; bus.req_hp = '0; bus.req_dur = '0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.grant, bus.busy, bus.done, bus.speaker} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000", {bus.grant, bus.busy, bus.done, bus.speaker});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        int n;
        logic exp;
        load(0, 3, 2);
        bus.req = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0001) begin errors++; $display("FAIL t1_grant got %b want 0001", bus.grant); end
        bus.req = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            exp = (c >= 3 && c < 6);
            checks++;
            if (bus.speaker !== exp || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL t1_play cyc %0d spk/busy/done got %b%b%b want %b10", c, bus.speaker, bus.busy, bus.done, exp);
            end
            if (c == 1) begin
                checks++;
                if (bus.grant !== 4'b0000) begin errors++; $display("FAIL t1_grant_pulse got %b want 0000", bus.grant); end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.speaker !== 1'b0) begin
            errors++; $display("FAIL t1_done done/spk got %b%b want 10", bus.done, bus.speaker);
        end
        wait_busy_low(n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL t1_gap_len got %0d want 8", n); end
    endtask

    task automatic test_priority();
        int n;
        load(1, 2, 1);
        load(3, 1, 1);
        bus.req = 4'b1010;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0010) begin errors++; $display("FAIL t2_grant_hi got %b want 0010", bus.grant); end
        bus.req = 4'b1000;
        wait_busy_low(n);
        checks++;
        if (n !== 12) begin errors++; $display("FAIL t2_busy_len got %0d want 12", n); end
        checks++;
        if (bus.grant !== 4'b0000) begin errors++; $display("FAIL t2_no_early_grant got %b want 0000", bus.grant); end
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b1000) begin errors++; $display("FAIL t2_grant_lo got %b want 1000", bus.grant); end
        bus.req = 4'b0000;
        wait_busy_low(n);
        checks++;
        if (n !== 12) begin errors++; $display("FAIL t2_busy_len2 got %0d want 12", n); end
    endtask

    task automatic test_rest();
        int n;
        logic heard;
        load(2, 0, 3);
        bus.req = 4'b0100;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0100) begin errors++; $display("FAIL t3_grant got %b want 0100", bus.grant); end
        bus.req = 4'b0000;
        heard = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.speaker !== 1'b0 || bus.done !== 1'b0) heard = 1'b1;
        end
        checks++;
        if (heard !== 1'b0) begin errors++; $display("FAIL t3_silent got %b want 0", heard); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL t3_done got %b want 1", bus.done); end
        wait_busy_low(n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL t3_total got %0d want 20", 12 + n); end
    endtask

    task automatic test_abort();
        int n;
        logic exp;
        load(0, 2, 5);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            exp = (c >= 2 && c < 4) || (c >= 6);
            checks++;
            if (bus.speaker !== exp || bus.done !== 1'b0) begin
                errors++; $display("FAIL t4_play cyc %0d spk/done got %b%b want %b0", c, bus.speaker, bus.done, exp);
            end
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.speaker !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL t4_abort spk/done/busy got %b%b%b want 011", bus.speaker, bus.done, bus.busy);
        end
        wait_busy_low(n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL t4_gap_len got %0d want 8", n); end
        // abort landing on the natural last PLAY cycle
        load(0, 0, 1);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL t4_end_abort_done got %b want 1", bus.done); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL t4_single_done got %b want 0", bus.done); end
        wait_busy_low(n);
        checks++;
        if (n !== 7) begin errors++; $display("FAIL t4_end_gap got %0d want 7", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        load(0, 2, 5);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.speaker !== 1'b1) begin errors++; $display("FAIL t5_pre_spk got %b want 1", bus.speaker); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.speaker, bus.busy, bus.done, bus.grant} !== 7'b0) begin
            errors++; $display("FAIL t5_reset spk/busy/done/grant got %b want 0000000", {bus.speaker, bus.busy, bus.done, bus.grant});
        end
        rst_n = 1'b1;
        load(1, 3, 1);
        bus.req = 4'b0010;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0010 || bus.done !== 1'b0) begin
            errors++; $display("FAIL t5_regrant grant/done got %b%b want 00100", bus.grant, bus.done);
        end
        bus.req = 4'b0000;
        wait_busy_low(n);
        checks++;
        if (n !== 12) begin errors++; $display("FAIL t5_busy_len got %0d want 12", n); end
    endtask

    task automatic test_zero_dur();
        int n;
        bus.abort = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL t6_idle_abort busy/done got %b%b want 00", bus.busy, bus.done);
        end
        load(0, 5, 0);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.req = 4'b0000;
        checks++;
        if (bus.grant !== 4'b0001 || bus.speaker !== 1'b0) begin
            errors++; $display("FAIL t6_grant grant/spk got %b%b want 00010", bus.grant, bus.speaker);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.speaker !== 1'b0) begin
            errors++; $display("FAIL t6_done done/spk got %b%b want 10", bus.done, bus.speaker);
        end
        wait_busy_low(n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL t6_gap_len got %0d want 8", n); end
    endtask

    initial begin
        test_reset();
        test_single();
        @(negedge clk);
        test_priority();
        @(negedge clk);
        test_rest();
        @(negedge clk);
        test_abort();
        @(negedge clk);
        test_reset_mid();
        @(negedge clk);
        test_zero_dur();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
